// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: access size codes, register word
// offsets, FSM states and lane helpers. Timer registers exist only with MMIO_TIMER_EN.
package mmio_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // Word index of each register inside the window starting at LED_ADDR
  localparam logic [1:0] REG_LED   = 2'd0;
  localparam logic [1:0] REG_CYCLE = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [2:0] m, input logic [1:0] off);
    case (m)
      MEM_B, MEM_BU: return 1'b0;
      MEM_H, MEM_HU: return off[0];
      default:       return |off;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] m, input logic [1:0] off);
    case (m)
      MEM_B, MEM_BU: return 4'b0001 << off;
      MEM_H, MEM_HU: return off[1] ? 4'b1100 : 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane; byte enables pick the live one
  function automatic logic [31:0] store_lanes(input logic [2:0] m, input logic [31:0] wd);
    case (m)
      MEM_B, MEM_BU: return {4{wd[7:0]}};
      MEM_H, MEM_HU: return {2{wd[15:0]}};
      default:       return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] m, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (m)
      MEM_B:   return {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  return {24'b0, sh[7:0]};
      MEM_H:   return {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  return {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Word-organised RAM with four byte-lane write enables and a registered read.
// Contents are never reset.
module byte_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++)
      if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mmio_responder.sv
// Single-port MMIO slave: RAM, LED register and optional CYCLE/CMP timer
// (enabled by MMIO_TIMER_EN). Every access completes in IDLE->ACCESS->RESP.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] LED_ADDR    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        led_indicator,
  output logic        misalign_err,
  output logic        timer_irq
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  state_e      r_state;
  logic        w_ram_hit, w_reg_hit, w_misalign, w_load, w_commit_store;
  logic [31:0] w_reg_off, w_ram_rdata, w_reg_rdata, w_word, w_cycle, w_cmp;
  logic [1:0]  w_reg_idx;
  logic [3:0]  w_ram_we;

  assign w_reg_off  = addr - LED_ADDR;
  assign w_reg_hit  = w_reg_off < 32'd12;
  assign w_reg_idx  = w_reg_off[3:2];
  assign w_ram_hit  = {1'b0, addr} < RAM_BYTES;
  assign w_misalign = misaligned(mem, addr[1:0]);
  assign w_load     = mem_read & ~mem_write;
  // A store takes effect on the ACCESS->RESP edge; reads happen alongside
  assign w_commit_store = (r_state == ST_ACCESS) && mem_write && !w_misalign;
  assign w_ram_we   = (w_commit_store && w_ram_hit) ? byte_en(mem, addr[1:0]) : 4'b0000;

  // RAM read is launched on the accept edge so data is ready during ACCESS
  byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (addr[AW+1:2]),
    .i_wdata (store_lanes(mem, write_data)),
    .o_rdata (w_ram_rdata)
  );

`ifdef MMIO_TIMER_EN
  logic [31:0] r_cycle, r_cmp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
      r_cmp   <= '1;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_commit_store && !w_ram_hit && w_reg_hit && w_reg_idx == REG_CMP)
        r_cmp <= write_data;
    end
  end

  assign w_cycle   = r_cycle;
  assign w_cmp     = r_cmp;
  assign timer_irq = r_cycle >= r_cmp;
`else
  assign w_cycle   = '0;
  assign w_cmp     = '0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    w_reg_rdata = '0;
    case (w_reg_idx)
      REG_LED:   w_reg_rdata = {31'b0, led_indicator};
      REG_CYCLE: w_reg_rdata = w_cycle;
      REG_CMP:   w_reg_rdata = w_cmp;
      default:   w_reg_rdata = '0;
    endcase
  end

  assign w_word = w_ram_hit ? w_ram_rdata : (w_reg_hit ? w_reg_rdata : 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      mem_ready     <= 1'b0;
      read_data     <= '0;
      led_indicator <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (mem_read || mem_write) r_state <= ST_ACCESS;
        ST_ACCESS: begin
          r_state   <= ST_RESP;
          mem_ready <= 1'b1;
          if (w_misalign) begin
            misalign_err <= 1'b1;
            if (w_load) read_data <= '0;
          end else begin
            if (w_load) read_data <= load_ext(mem, addr[1:0], w_word);
            if (mem_write && !w_ram_hit && w_reg_hit && w_reg_idx == REG_LED)
              led_indicator <= write_data[0];
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter LED_ADDR, default 32'h8000_0000, base of the register window (LED, +4 CYCLE, +8 CMP).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read  in  1  load request.
REQ-006 SHALL have port mem_write  in  1  store request.
REQ-007 SHALL have port mem  in  3  size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port addr  in  32  byte address.
REQ-009 SHALL have port write_data  in  32  store data, right-aligned.
REQ-010 SHALL have port read_data  out  32  load result, extended per mem.
REQ-011 SHALL have port mem_ready  out  1  one-cycle completion pulse.
REQ-012 SHALL have port led_indicator  out  1  LED register bit 0.
REQ-013 SHALL have port misalign_err  out  1  sticky misaligned-access flag.
REQ-014 SHALL have port timer_irq  out  1  level, high while CYCLE >= CMP.

Function
REQ-015 SHALL use FSM IDLE -> ACCESS -> RESP -> IDLE; a request is accepted in IDLE when mem_read or mem_write is high.
REQ-016 SHALL require the initiator to hold mem_read, mem_write, mem, addr, write_data stable until mem_ready; behaviour otherwise undefined.
REQ-017 SHALL perform stores in ACCESS and pulse mem_ready in RESP: ready exactly 2 cycles after acceptance for both loads and stores.
REQ-018 SHALL present load data on read_data in RESP and hold it until the next load's RESP.
REQ-019 SHALL perform only the store when mem_read and mem_write are both high, returning read_data unchanged.
REQ-020 SHALL decode addr < DEPTH_WORDS*4 as RAM, LED_ADDR..LED_ADDR+8 as registers, all else unmapped.
REQ-021 SHALL, for RAM stores, write only the addressed byte/halfword lanes via byte enables from addr[1:0].
REQ-022 SHALL sign-extend B/H and zero-extend BU/HU loads; W returns the full word.
REQ-023 SHALL treat H/HU with addr[0]=1 or W with addr[1:0]!=0 as misaligned: no write, read_data=0, misalign_err set, mem_ready still pulsed.
REQ-024 SHALL ignore stores to unmapped addresses and return 0 for unmapped loads, with no error flag.
REQ-025 SHALL write the LED register (bit 0 only) and CMP register (full 32 bits) on register-window stores of any size; CYCLE is read-only.
REQ-026 SHALL increment CYCLE every clk cycle, wrapping 32'hFFFF_FFFF -> 0; timer_irq re-evaluates after wrap.
REQ-027 SHALL return mem_ready for the current request only once; a request still held in IDLE after RESP is accepted as a new request.

Reset
REQ-028 SHALL on reset low, immediately: FSM IDLE, mem_ready=0, read_data=0, led_indicator=0, misalign_err=0, CYCLE=0, CMP=32'hFFFF_FFFF, timer_irq=0.
REQ-029 SHALL abort any in-flight access on reset; a store in ACCESS at reset assertion MAY or MAY NOT reach RAM; RAM contents are not reset.

Configuration
REQ-030 SHALL with MMIO_TIMER_EN defined implement CYCLE, CMP and timer_irq as above.
REQ-031 SHALL without MMIO_TIMER_EN omit CYCLE/CMP logic: those addresses read 0, stores ignored, timer_irq tied 0.

Structure
REQ-032 SHALL place size codes, register offsets and the FSM state enum in shared package mmio_pkg.
REQ-033 SHALL implement RAM as sub-module byte_ram (synchronous read, 4 byte-enable write lanes, DEPTH_WORDS parameter).

Verification
REQ-034 SHALL test SW 0xDEADBEEF @0x10, then LB @0x13 -> read_data=0xFFFFFFDE, LBU @0x13 -> 0x000000DE, LHU @0x10 -> 0x0000BEEF.
REQ-035 SHALL test SB 0x12 @0x21 over word 0 -> LW @0x20 = 0x00001200; mem_ready 2 cycles after each request.
REQ-036 SHALL test LW @0x22 -> read_data=0, misalign_err=1 and stays 1; prior RAM word unchanged.
REQ-037 SHALL test SW 1 @LED_ADDR -> led_indicator=1 at RESP; LW @0x4000_0000 -> 0.
REQ-038 SHALL test (MMIO_TIMER_EN) SW 20 @CMP -> timer_irq rises when CYCLE reaches 20; without macro stays 0.
REQ-039 SHALL test reset asserted in ACCESS -> all outputs at reset values same cycle, next request served normally.
